// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared opcodes, ALU codes, FSM states and decode helper for ctrl_fsm
package ctrl_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001
  } aluctrl_e;

  typedef enum logic [2:0] {
    RESET,
    FETCH,
    DECODE,
    EXEC,
    TRAP
  } state_e;

  typedef enum logic [2:0] {
    I_ADDI,
    I_ADD,
    I_SUB,
    I_BNE,
    I_ILLEGAL
  } instr_e;

  function automatic instr_e classify(input logic [31:0] ir);
    instr_e c;
    c = I_ILLEGAL;
    if (ir[6:0] == OP_IMM && ir[14:12] == F3_ADD)
      c = I_ADDI;
    else if (ir[6:0] == OP_REG && ir[14:12] == F3_ADD && ir[31:25] == F7_ADD)
      c = I_ADD;
    else if (ir[6:0] == OP_REG && ir[14:12] == F3_ADD && ir[31:25] == F7_SUB)
      c = I_SUB;
    else if (ir[6:0] == OP_BRANCH && ir[14:12] == F3_BNE)
      c = I_BNE;
    return c;
  endfunction

endpackage

// File: rtl/ctrl_fsm_if.sv
// rtl/ctrl_fsm_if.sv - instruction-memory fetch handshake between ctrl_fsm and imem
interface ctrl_fsm_if #(
  parameter int PC_WIDTH = 32
);
  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic [31:0]         imem_rdata;
  logic                imem_valid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );
endinterface

// File: rtl/ctrl_fsm_imm_gen.sv
// rtl/ctrl_fsm_imm_gen.sv - I-type and B-type sign-extended immediates from the instruction word
module imm_gen #(
  parameter int D_WIDTH = 32
) (
  input  logic [31:0]        ir,
  output logic [D_WIDTH-1:0] imm_i,
  output logic [D_WIDTH-1:0] imm_b
);
  logic [11:0] i12;
  logic [12:0] b13;
  logic        unused_ir_bits;

  assign i12 = ir[31:20];
  assign b13 = {ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};

  // size cast of a signed operand sign-extends or truncates to D_WIDTH
  assign imm_i = D_WIDTH'($signed(i12));
  assign imm_b = D_WIDTH'($signed(b13));

  assign unused_ir_bits = ^{ir[19:12], ir[6:0]};
endmodule

// File: rtl/ctrl_fsm.sv
// rtl/ctrl_fsm.sv - multi-cycle fetch/decode/exec control unit for the addi/add/sub/bne subset
module ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int                  A_WIDTH  = 5,
  parameter int                  D_WIDTH  = 32,
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  ctrl_fsm_if.master          imem,
  input  logic                eq,
  output logic [A_WIDTH-1:0]  ad1,
  output logic [A_WIDTH-1:0]  ad2,
  output logic [A_WIDTH-1:0]  ad3,
  output logic                we3,
  output logic [D_WIDTH-1:0]  imm_op,
  output logic                alusrc,
  output logic [2:0]          aluctrl,
  output logic [PC_WIDTH-1:0] pc,
  output logic                trap
);
  state_e              state;
  logic [31:0]         ir;
  instr_e              cls;
  logic [D_WIDTH-1:0]  imm_i;
  logic [D_WIDTH-1:0]  imm_b;
  logic [PC_WIDTH-1:0] br_off;
  logic                rd_nz;

  imm_gen #(.D_WIDTH(D_WIDTH)) u_imm_gen (
    .ir    (ir),
    .imm_i (imm_i),
    .imm_b (imm_b)
  );

  assign cls   = classify(ir);
  assign rd_nz = (ir[11:7] != 5'd0);

  assign ad1 = A_WIDTH'(ir[19:15]);
  assign ad2 = A_WIDTH'(ir[24:20]);
  assign ad3 = A_WIDTH'(ir[11:7]);

  assign imem.imem_addr = pc;

  // branch offset re-sized from datapath width into PC arithmetic width
  assign br_off = PC_WIDTH'($signed(imm_op));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RESET;
      pc            <= RESET_PC;
      ir            <= '0;
      imm_op        <= '0;
      imem.imem_req <= 1'b0;
      we3           <= 1'b0;
      alusrc        <= 1'b0;
      aluctrl       <= ALU_ADD;
      trap          <= 1'b0;
    end else begin
      case (state)
        RESET: begin
          state         <= FETCH;
          imem.imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem.imem_valid) begin
            ir            <= imem.imem_rdata;
            imem.imem_req <= 1'b0;
            state         <= DECODE;
          end
        end
        DECODE: begin
          imm_op <= (cls == I_BNE) ? imm_b : imm_i;
          if (cls == I_ILLEGAL) begin
            state <= TRAP;
            trap  <= 1'b1;
          end else begin
            state   <= EXEC;
            alusrc  <= (cls == I_ADDI);
            aluctrl <= (cls == I_ADDI || cls == I_ADD) ? ALU_ADD : ALU_SUB;
            we3     <= (cls != I_BNE) && rd_nz;
          end
        end
        EXEC: begin
          // eq is the datapath's same-cycle compare of rs1/rs2
          if (cls == I_BNE && !eq)
            pc <= pc + br_off;
          else
            pc <= pc + PC_WIDTH'(4);
          we3           <= 1'b0;
          alusrc        <= 1'b0;
          aluctrl       <= ALU_ADD;
          imem.imem_req <= 1'b1;
          state         <= FETCH;
        end
        TRAP: begin
          state <= TRAP;
        end
        default: begin
          state         <= TRAP;
          trap          <= 1'b1;
          imem.imem_req <= 1'b0;
          we3           <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ctrl_fsm.sv
// tb/tb_ctrl_fsm.sv - trace-model bench for ctrl_fsm
module tb_ctrl_fsm;
  localparam int          AW  = 5;
  localparam int          DW  = 32;
  localparam int          PW  = 32;
  localparam logic [31:0] RPC = 32'h0;

  localparam int K_ADDI = 0;
  localparam int K_ADD  = 1;
  localparam int K_SUB  = 2;
  localparam int K_BNE  = 3;
  localparam int K_ILL  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          eq;
  logic [AW-1:0] ad1, ad2, ad3;
  logic          we3;
  logic [DW-1:0] imm_op;
  logic          alusrc;
  logic [2:0]    aluctrl;
  logic [PW-1:0] pc;
  logic          trap;

  always #5 clk = ~clk;

  ctrl_fsm_if #(.PC_WIDTH(PW)) imem ();

  ctrl_fsm #(.A_WIDTH(AW), .D_WIDTH(DW), .PC_WIDTH(PW), .RESET_PC(RPC)) dut (
    .clk     (clk),
    .rst     (rst),
    .imem    (imem),
    .eq      (eq),
    .ad1     (ad1),
    .ad2     (ad2),
    .ad3     (ad3),
    .we3     (we3),
    .imm_op  (imm_op),
    .alusrc  (alusrc),
    .aluctrl (aluctrl),
    .pc      (pc),
    .trap    (trap)
  );

  typedef struct {
    bit          rst;
    bit          valid;
    bit          eq;
    logic [31:0] rdata;
    bit          req;
    logic [31:0] addr;
    logic [31:0] pcv;
    bit          we3;
    bit          trap;
    bit          chk_ad;
    logic [4:0]  a1, a2, a3;
    bit          chk_exec;
    logic [31:0] imm;
    bit          alusrc;
    logic [2:0]  aluctrl;
  } rec_t;

  rec_t        trace[$];
  rec_t        cur;
  logic [31:0] mpc;
  bit          running = 0;
  int          checks  = 0;
  int          errors  = 0;
  int          mark_addi, mark_bne0, mark_bne1, mark_trap, mark_x0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_kind(input logic [31:0] w);
    int opc, f3, f7;
    opc = int'(w & 32'h7F);
    f3  = int'((w >> 12) & 32'h7);
    f7  = int'(w >> 25);
    if (opc == 'h13 && f3 == 0) return K_ADDI;
    if (opc == 'h33 && f3 == 0 && f7 == 0) return K_ADD;
    if (opc == 'h33 && f3 == 0 && f7 == 'h20) return K_SUB;
    if (opc == 'h63 && f3 == 1) return K_BNE;
    return K_ILL;
  endfunction

  function automatic int m_imm_i(input logic [31:0] w);
    int s;
    s = int'(w);
    return s >>> 20;
  endfunction

  function automatic int m_imm_b(input logic [31:0] w);
    int v;
    v = -4096 * int'((w >> 31) & 1) + 2048 * int'((w >> 7) & 1)
        + 32 * int'((w >> 25) & 63) + 2 * int'((w >> 8) & 15);
    return v;
  endfunction

  function automatic rec_t blank();
    rec_t r;
    r = '{default: 0};
    r.rdata = $urandom;
    r.eq    = 1'($urandom);
    r.addr  = mpc;
    r.pcv   = mpc;
    return r;
  endfunction

  task automatic fields(inout rec_t r, input logic [31:0] w);
    r.chk_ad = 1;
    r.a1     = 5'((w >> 15) & 31);
    r.a2     = 5'((w >> 20) & 31);
    r.a3     = 5'((w >> 7) & 31);
  endtask

  task automatic add_reset(input int n, input bit late_valid, input logic [31:0] late_word);
    rec_t r;
    mpc = RPC;
    for (int i = 0; i < n; i++) begin
      r = blank();
      r.rst = 1;
      r.valid = 1'($urandom);
      fields(r, 32'h0);
      trace.push_back(r);
    end
    r = blank();
    r.valid = late_valid;
    r.rdata = late_word;
    fields(r, 32'h0);
    trace.push_back(r);
  endtask

  task automatic add_fetch_idle();
    rec_t r;
    r = blank();
    r.req = 1;
    fields(r, 32'h0);
    trace.push_back(r);
  endtask

  task automatic add_instr(input logic [31:0] w, input int wait_n, input bit e);
    rec_t r;
    int   k;
    int   imm;
    k = m_kind(w);
    for (int i = 0; i <= wait_n; i++) begin
      r = blank();
      r.req   = 1;
      r.valid = (i == wait_n);
      if (r.valid) r.rdata = w;
      trace.push_back(r);
    end
    r = blank();
    r.valid = 1;
    fields(r, w);
    trace.push_back(r);
    if (k == K_ILL) begin
      for (int i = 0; i < 4; i++) begin
        r = blank();
        r.valid = 1'($urandom);
        r.trap  = 1;
        fields(r, w);
        trace.push_back(r);
      end
      return;
    end
    imm = (k == K_BNE) ? m_imm_b(w) : m_imm_i(w);
    r = blank();
    r.valid    = 1;
    r.eq       = e;
    fields(r, w);
    r.chk_exec = 1;
    r.imm      = imm;
    r.alusrc   = (k == K_ADDI);
    r.aluctrl  = (k == K_SUB || k == K_BNE) ? 3'd1 : 3'd0;
    r.we3      = (k != K_BNE) && (((w >> 7) & 31) != 0);
    trace.push_back(r);
    if (k == K_BNE && !e) mpc = mpc + imm;
    else mpc = mpc + 32'd4;
  endtask

  always @(negedge clk) begin
    if (running) begin
      chk("imem_req", imem.imem_req, cur.req);
      chk("imem_addr", imem.imem_addr, cur.addr);
      chk("pc", pc, cur.pcv);
      chk("we3", we3, cur.we3);
      chk("trap", trap, cur.trap);
      if (cur.chk_ad) begin
        chk("ad1", ad1, cur.a1);
        chk("ad2", ad2, cur.a2);
        chk("ad3", ad3, cur.a3);
      end
      if (cur.chk_exec) begin
        chk("imm_op", imm_op, cur.imm);
        chk("alusrc", alusrc, cur.alusrc);
        chk("aluctrl", aluctrl, cur.aluctrl);
      end
    end
  end

  initial begin
    int n0;
    mpc = RPC;
    add_reset(2, 1'b0, 32'h0);
    add_instr(32'h00500093, 0, 1'b0);
    mark_addi = trace.size() - 1;
    chk("pin_addi_pc", mpc, 32'd4);
    add_instr(32'h00700113, 0, 1'b1);
    add_instr(32'hFE209EE3, 0, 1'b0);
    mark_bne0 = trace.size() - 1;
    chk("pin_bne_imm", 64'(m_imm_b(32'hFE209EE3)), 64'(-4));
    chk("pin_bne_taken", mpc, 32'd4);
    add_instr(32'h00100013, 0, 1'b0);
    mark_x0 = trace.size() - 1;
    add_instr(32'hFE209EE3, 0, 1'b1);
    mark_bne1 = trace.size() - 1;
    n0 = trace.size();
    add_instr(32'h402081B3, 3, 1'b0);
    chk("pin_sub_cycles", trace.size() - n0, 6);
    add_instr(32'h00208233, 1, 1'b1);
    add_instr(32'h00209063, 0, 1'b0);
    chk("pin_spin_pc", mpc, 32'd20);
    add_instr(32'h00209063, 0, 1'b1);
    add_instr(32'hFFFFFFFF, 0, 1'b0);
    mark_trap = trace.size() - 4;
    add_reset(2, 1'b0, 32'h0);
    add_fetch_idle();
    add_reset(1, 1'b1, 32'h00A00113);
    add_fetch_idle();
    add_instr(32'h00500093, 0, 1'b0);

    running = 1;
    for (int k = 0; k < trace.size(); k++) begin
      cur              = trace[k];
      rst              = cur.rst;
      imem.imem_valid  = cur.valid;
      imem.imem_rdata  = cur.rdata;
      eq               = cur.eq;
      @(posedge clk);
      #1;
      if (k == mark_addi) chk("lit_pc_after_addi", pc, 32'd4);
      if (k == mark_bne0) chk("lit_addr_bne_eq0", imem.imem_addr, 32'd4);
      if (k == mark_bne1) chk("lit_addr_bne_eq1", imem.imem_addr, 32'd12);
      if (k == mark_x0) chk("lit_x0_pc", pc, 32'd8);
      if (k == mark_trap) chk("lit_trap_set", trap, 1'b1);
    end
    running = 0;
    chk("lit_final_pc", pc, 32'd4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
